// File: rtl/keyboard_mole_key_scheduler.sv
// PS/2 scan-code decoder for the whac-a-mole game: tracks held state of the nine
// game keys and queues one press event per new key-down toward the game FSM.
module keyboard_mole_key_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       scan_ready,
    input  logic [7:0] scan_code,
    input  logic       key_ready,
    input  logic       clear_overflow,
    output logic       key_valid,
    output logic [3:0] key_index,
    output logic [8:0] held,
    output logic       overflow
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_BREAK     = 2'd1;
    localparam logic [1:0] ST_EXT       = 2'd2;
    localparam logic [1:0] ST_EXT_BREAK = 2'd3;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          scan_ready_q, scan_ready_d;
    logic [8:0]    held_q, held_d;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [3:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic       accept;
    logic       map_hit;
    logic [3:0] map_idx;
    logic       push_req;
    logic       push_ok;
    logic       drop;
    logic       pop;
    logic       full;

    always_comb begin
        map_hit = 1'b1;
        map_idx = 4'd0;
        case (scan_code)
            8'h15:   map_idx = 4'd0;
            8'h1D:   map_idx = 4'd1;
            8'h24:   map_idx = 4'd2;
            8'h1C:   map_idx = 4'd3;
            8'h1B:   map_idx = 4'd4;
            8'h23:   map_idx = 4'd5;
            8'h1A:   map_idx = 4'd6;
            8'h22:   map_idx = 4'd7;
            8'h21:   map_idx = 4'd8;
            default: map_hit = 1'b0;
        endcase
    end

    assign accept       = scan_ready & ~scan_ready_q;
    assign scan_ready_d = scan_ready;

    // Decoder and prefix timeout; an accept in the same cycle as expiry is decoded
    // against the still-pending prefix.
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        held_d   = held_q;
        push_req = 1'b0;
        if (accept) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (scan_code == 8'hF0) begin
                        state_d = ST_BREAK;
                    end else if (map_hit && !held_q[map_idx]) begin
                        held_d[map_idx] = 1'b1;
                        push_req        = 1'b1;
                    end
                end
                ST_BREAK: begin
                    state_d = ST_IDLE;
                    if (map_hit) begin
                        held_d[map_idx] = 1'b0;
                    end
                end
                ST_EXT: begin
                    state_d = (scan_code == 8'hF0) ? ST_EXT_BREAK : ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    assign key_valid = (count_q != '0);
    assign full      = (count_q == CNT_FULL);
    assign pop       = key_valid & key_ready;
    assign push_ok   = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = map_idx;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            tmo_q        <= '0;
            scan_ready_q <= 1'b0;
            held_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            scan_ready_q <= scan_ready_d;
            held_q       <= held_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            mem_q        <= mem_d;
        end
    end

    assign key_index = key_valid ? mem_q[rd_ptr_q] : 4'd0;
    assign held      = held_q;
    assign overflow  = overflow_q;

endmodule
